// File: rtl/notas_pkg.sv
// rtl/notas_pkg.sv - note code range constants and melody sequencer state encoding
package notas_pkg;

    localparam logic [3:0] NOTA_SILENCIO = 4'd0;
    localparam logic [3:0] NOTA_MIN      = 4'd1;
    localparam logic [3:0] NOTA_MAX      = 4'd13;

    typedef enum logic [2:0] {
        INICIAL = 3'd0,
        BUSCA   = 3'd1,
        TOCA    = 3'd2,
        PAUSA   = 3'd3,
        PROXIMA = 3'd4,
        FIM     = 3'd5
    } estado_t;

    // Codes outside 1..13 are rests: they keep the slot timing but stay silent
    function automatic logic nota_valida(input logic [3:0] nota);
        return (nota != NOTA_SILENCIO) && (nota >= NOTA_MIN) && (nota <= NOTA_MAX);
    endfunction

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - up-counter whose modulus (ultimo+1) is chosen at run time
module contador_m #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    input  logic [W-1:0] ultimo,
    output logic         fim
);

    localparam logic [W-1:0] UM = 1;

    logic [W-1:0] r_q;
    logic         w_fim;

    assign w_fim = (r_q == ultimo);
    assign fim   = w_fim;

    // Wrapping at the terminal count hands the next phase a cleared counter
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            r_q <= '0;
        end else if (conta) begin
            r_q <= w_fim ? '0 : r_q + UM;
        end
    end

endmodule

// File: rtl/controlador_notas.sv
// rtl/controlador_notas.sv - plays note memory entries 0..limite with fixed note and gap times
module controlador_notas
    import notas_pkg::*;
#(
    parameter int ADDR_W        = 4,
    parameter int DURACAO_NOTA  = 1000,
    parameter int DURACAO_PAUSA = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              parar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [3:0]        dado_nota,
    output logic [ADDR_W-1:0] endereco,
    output logic [3:0]        valor,
    output logic              enable_nota,
    output logic              tocando,
    output logic              pronto
);

    localparam int DMAX = (DURACAO_NOTA > DURACAO_PAUSA) ? DURACAO_NOTA : DURACAO_PAUSA;
    localparam int CW   = $clog2(DMAX + 1);
    localparam logic [CW-1:0]     ULT_NOTA  = CW'(DURACAO_NOTA - 1);
    localparam logic [CW-1:0]     ULT_PAUSA = CW'(DURACAO_PAUSA - 1);
    localparam logic [ADDR_W-1:0] UM        = 1;

    estado_t           r_estado;
    logic [ADDR_W-1:0] r_endereco;
    logic [ADDR_W-1:0] r_limite;
    logic [3:0]        r_valor;
    logic              r_valido;

    logic              w_conta;
    logic              w_fim;
    logic [CW-1:0]     w_ultimo;

    assign w_conta  = (r_estado == TOCA) || (r_estado == PAUSA);
    assign w_ultimo = (r_estado == TOCA) ? ULT_NOTA : ULT_PAUSA;

    contador_m #(.W(CW)) u_contador (
        .clock  (clock),
        .reset  (reset),
        .zera   (!w_conta),
        .conta  (w_conta),
        .ultimo (w_ultimo),
        .fim    (w_fim)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_endereco <= '0;
            r_limite   <= '0;
            r_valor    <= '0;
            r_valido   <= 1'b0;
        end else if (parar && (r_estado != INICIAL)) begin
            r_estado <= INICIAL;
        end else begin
            case (r_estado)
                INICIAL: begin
                    if (iniciar && !parar) begin
                        r_limite   <= limite;
                        r_endereco <= '0;
                        r_estado   <= BUSCA;
                    end
                end
                BUSCA: begin
                    r_valor  <= dado_nota;
                    r_valido <= nota_valida(dado_nota);
                    r_estado <= TOCA;
                end
                TOCA:  if (w_fim) r_estado <= PAUSA;
                PAUSA: if (w_fim) r_estado <= PROXIMA;
                PROXIMA: begin
                    // Compare before incrementing so limite = all-ones never wraps
                    if (r_endereco == r_limite) begin
                        r_estado <= FIM;
                    end else begin
                        r_endereco <= r_endereco + UM;
                        r_estado   <= BUSCA;
                    end
                end
                FIM:     r_estado <= INICIAL;
                default: r_estado <= INICIAL;
            endcase
        end
    end

    assign endereco    = r_endereco;
    assign valor       = r_valor;
    assign enable_nota = (r_estado == TOCA) && r_valido;
    assign tocando     = (r_estado != INICIAL) && (r_estado != FIM);
    assign pronto      = (r_estado == FIM);

endmodule

// File: tb/tb_controlador_notas.sv
// tb/tb_controlador_notas.sv - self-checking bench for controlador_notas
module tb_controlador_notas;

    localparam int DN = 4;
    localparam int DP = 2;
    localparam int P  = DN + DP + 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic [3:0] limite;
    logic [3:0] dado_nota;
    logic [3:0] endereco;
    logic [3:0] valor;
    logic       enable_nota;
    logic       tocando;
    logic       pronto;

    logic [3:0] mem [16];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign dado_nota = mem[endereco];

    controlador_notas #(.ADDR_W(4), .DURACAO_NOTA(DN), .DURACAO_PAUSA(DP)) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .parar       (parar),
        .limite      (limite),
        .dado_nota   (dado_nota),
        .endereco    (endereco),
        .valor       (valor),
        .enable_nota (enable_nota),
        .tocando     (tocando),
        .pronto      (pronto)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected outputs in cycle c after a start: slot j = (c-1)/P, offset o inside the slot.
    // Layout {endereco[10:7], valor[6:3], enable[2], tocando[1], pronto[0]}.
    function automatic void modelo(input int c, input int n, output logic [10:0] v, output logic [10:0] m);
        int j, o;
        logic [3:0] e, vl;
        logic en, tc, pr;
        m = '1;
        if (c >= n * P + 1) begin
            e = 4'(n - 1); vl = mem[n - 1]; en = 1'b0; tc = 1'b0; pr = (c == n * P + 1);
        end else begin
            j = (c - 1) / P;
            o = (c - 1) % P;
            e = 4'(j); tc = 1'b1; pr = 1'b0;
            en = (o >= 1) && (o <= DN) && (mem[j] >= 4'd1) && (mem[j] <= 4'd13);
            if (o == 0) begin
                vl = (j == 0) ? 4'd0 : mem[j - 1];
                if (j == 0) m[6:3] = 4'd0;
            end else begin
                vl = mem[j];
            end
        end
        v = {e, vl, en, tc, pr};
    endfunction

    function automatic logic [10:0] obs();
        return {endereco, valor, enable_nota, tocando, pronto};
    endfunction

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b0; parar = 1'b0; limite = 4'd0;
        tick(); tick();
        n_checks++;
        if (obs() !== 11'd0) begin
            n_fail++; $display("FAIL reset got=%h exp=%h", obs(), 11'd0);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_melodia(input string nome, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        logic [10:0] ev, em;
        int pulsos = 0;
        mem[0] = a; mem[1] = b; mem[2] = d;
        iniciar = 1'b1; limite = 4'd2; tick(); iniciar = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            modelo(c, 3, ev, em);
            pulsos += int'(pronto);
            n_checks++;
            if ((obs() & em) !== (ev & em)) begin
                n_fail++; $display("FAIL %s c=%0d got=%h exp=%h", nome, c, obs() & em, ev & em);
            end
            tick();
        end
        n_checks++;
        if (pulsos != 1) begin
            n_fail++; $display("FAIL %s_pronto_pulses got=%0d exp=1", nome, pulsos);
        end
    endtask

    task automatic test_aleatorio();
        logic [10:0] ev, em;
        int n;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 16; k++) mem[k] = 4'($urandom_range(0, 15));
            n = (it == 0) ? 16 : int'($urandom_range(1, 16));
            iniciar = 1'b1; limite = 4'(n - 1); tick(); iniciar = 1'b0;
            for (int c = 1; c <= n * P + 2; c++) begin
                modelo(c, n, ev, em);
                n_checks++;
                if ((obs() & em) !== (ev & em)) begin
                    n_fail++; $display("FAIL random n=%0d c=%0d got=%h exp=%h", n, c, obs() & em, ev & em);
                end
                tick();
            end
        end
    endtask

    task automatic test_limite_muda();
        logic [10:0] ev, em;
        mem[0] = 4'd9; mem[1] = 4'd3; mem[2] = 4'd11;
        iniciar = 1'b1; limite = 4'd1; tick(); iniciar = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            if (c == 3) limite = 4'd0;
            modelo(c, 2, ev, em);
            n_checks++;
            if ((obs() & em) !== (ev & em)) begin
                n_fail++; $display("FAIL limite_change c=%0d got=%h exp=%h", c, obs() & em, ev & em);
            end
            tick();
        end
    endtask

    task automatic test_iniciar_ignorado();
        logic [10:0] ev, em;
        mem[0] = 4'd5; mem[1] = 4'd1; mem[2] = 4'd13;
        iniciar = 1'b1; limite = 4'd2; tick(); iniciar = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            iniciar = (c == 6);
            modelo(c, 3, ev, em);
            n_checks++;
            if ((obs() & em) !== (ev & em)) begin
                n_fail++; $display("FAIL iniciar_ignored c=%0d got=%h exp=%h", c, obs() & em, ev & em);
            end
            tick();
        end
        iniciar = 1'b0;
    endtask

    task automatic test_parar();
        logic [10:0] ev, em;
        int pulsos = 0;
        mem[0] = 4'd5; mem[1] = 4'd1; mem[2] = 4'd13;
        iniciar = 1'b1; limite = 4'd2; tick(); iniciar = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            parar   = (c == 11) || (c == 16);
            iniciar = (c == 14);
            if (c <= 11) begin
                modelo(c, 3, ev, em);
            end else if (c == 15) begin
                ev = {4'd0, 4'd0, 3'b010}; em = {4'hf, 4'h0, 3'b111};
            end else if (c == 16) begin
                ev = {4'd0, 4'd5, 3'b110}; em = '1;
            end else begin
                ev = 11'd0; em = {4'h0, 4'h0, 3'b111};
            end
            pulsos += int'(pronto);
            n_checks++;
            if ((obs() & em) !== (ev & em)) begin
                n_fail++; $display("FAIL parar c=%0d got=%h exp=%h", c, obs() & em, ev & em);
            end
            tick();
        end
        parar = 1'b0; iniciar = 1'b0;
        n_checks++;
        if (pulsos != 0) begin
            n_fail++; $display("FAIL parar_no_pronto got=%0d exp=0", pulsos);
        end
    endtask

    task automatic test_reset_meio();
        logic [10:0] ev, em;
        mem[0] = 4'd2; mem[1] = 4'd8; mem[2] = 4'd12;
        iniciar = 1'b1; limite = 4'd2; tick(); iniciar = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            reset   = (c == 12);
            iniciar = (c == 20);
            parar   = (c == 20);
            if (c <= 12) modelo(c, 3, ev, em);
            else begin ev = 11'd0; em = '1; end
            n_checks++;
            if ((obs() & em) !== (ev & em)) begin
                n_fail++; $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs() & em, ev & em);
            end
            tick();
        end
        reset = 1'b0; iniciar = 1'b0; parar = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 4'd0;
        test_reset();
        test_melodia("basic", 4'd5, 4'd1, 4'd13);
        test_melodia("rests", 4'd0, 4'd15, 4'd7);
        test_limite_muda();
        test_iniciar_ignorado();
        test_parar();
        test_reset_meio();
        test_aleatorio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_notas.md
# controlador_notas

Sequencer that plays a stored melody through the note decoder: on `iniciar` it walks a note memory from address 0 to a latched last address. For each entry it drives the 4-bit note code and a gated enable for a fixed note time, then a fixed silent gap. It sits between the game/playback control unit (start/stop, length) and the note memory + `decoder_nota` pair, and returns a one-cycle `pronto` when the melody ends.

## Interface
Parameters:
- `ADDR_W`, 4: note memory address width (up to 16 notes).
- `DURACAO_NOTA`, 1000: cycles a note is held (≥1).
- `DURACAO_PAUSA`, 250: silent cycles after each note (≥1).

Ports:
- `clock`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `iniciar`, in, 1: start request, sampled only in INICIAL.
- `parar`, in, 1: abort request, level-sampled every cycle.
- `limite`, in, ADDR_W: index of last note; latched at start.
- `dado_nota`, in, 4: memory data; valid one cycle after `endereco` changes.
- `endereco`, out, ADDR_W: memory address (registered).
- `valor`, out, 4: note code to decoder (registered).
- `enable_nota`, out, 1: decoder enable.
- `tocando`, out, 1: high in every state except INICIAL and FIM.
- `pronto`, out, 1: one-cycle pulse at normal completion.

## Operation
- States: INICIAL, BUSCA, TOCA, PAUSA, PROXIMA, FIM.
- INICIAL: outputs idle. On `iniciar`=1 and `parar`=0: latch `limite`, `endereco`←0, go to BUSCA.
- BUSCA (1 cycle): memory access. On exit, `valor`←`dado_nota`, clear counter, go to TOCA.
- TOCA (DURACAO_NOTA cycles): `enable_nota`=1 if 1≤`valor`≤13. Codes 0, 14, 15 are rests, with `enable_nota`=0 and identical timing. At terminal count, clear counter and go to PAUSA.
- PAUSA (DURACAO_PAUSA cycles): `enable_nota`=0, `valor` held. At terminal count, go to PROXIMA.
- PROXIMA (1 cycle): if `endereco`==latched limite, go to FIM. Otherwise `endereco`+1 and go to BUSCA.
- FIM (1 cycle): `pronto`=1, then INICIAL. `valor` and `endereco` keep last values until the next start.
- `parar`=1 in any state other than INICIAL: next state INICIAL, `enable_nota`=0 from the next cycle, no `pronto`.
- `iniciar` outside INICIAL is ignored. `iniciar` and `parar` both high in INICIAL: stay in INICIAL.
- Changes on `limite` after start have no effect.
- `endereco` never wraps. `limite`=2^ADDR_W−1 plays all entries and ends via FIM.

## Timing
- Reset values: state INICIAL, `endereco`=0, `valor`=0, `enable_nota`=0, `tocando`=0, `pronto`=0, counter 0.
- Reset mid-melody: same as above on the next edge, no `pronto`.
- `iniciar` sampled at edge k: BUSCA during cycle k+1, first `enable_nota` high during cycle k+2.
- Per-note period: DURACAO_NOTA+DURACAO_PAUSA+2 cycles.
- For N=`limite`+1 notes: FIM (pronto high) in cycle k+1+N·(DURACAO_NOTA+DURACAO_PAUSA+2). INICIAL follows in the next cycle.
- Counter width: $clog2(max(DURACAO_NOTA, DURACAO_PAUSA)+1). Terminal count is value DURACAO−1.
- `enable_nota` is decoded from the registered state plus a registered valid-note flag, so it is glitch-free.

## Structure
- Shared package/header `notas_pkg` holds `NOTA_SILENCIO`=0, `NOTA_MIN`=1, `NOTA_MAX`=13, and the state encoding. The note-range constants are shared with `decoder_nota` and the keyboard logic.
- One sub-module: `contador_m`, a generic modulo-M up-counter with `zera`/`conta` inputs and a `fim` output, instantiated once and reused for note and gap timing. The FSM stays in this block.

## Test plan
All scenarios use `DURACAO_NOTA`=4, `DURACAO_PAUSA`=2, `ADDR_W`=4 (period 8).
- Memory {5,1,13}, `limite`=2, `iniciar` at edge 0:
  - `endereco` goes 0,1,2.
  - `enable_nota` is high in cycles 2–5, 10–13 and 18–21 with `valor` 5, 1, 13.
  - `pronto` is high only in cycle 25; `tocando` is low from cycle 25.
- Memory {0,15,7}, `limite`=2: `enable_nota` stays low in slots 0 and 1, is high in cycles 18–21 with `valor`=7, and `pronto` fires in cycle 25.
- Start with `limite`=1, change `limite` to 0 in cycle 3: two notes are still played, and `pronto` fires in cycle 17.
- `parar` at cycle 11 during note 1: `enable_nota` is 0 from cycle 12, the state is INICIAL, and `pronto` is never asserted.
  - A new `iniciar` at cycle 14 restarts at `endereco`=0.
- `iniciar` pulsed again at cycle 6 mid-melody: ignored, timing identical to the first scenario.
- `reset` at cycle 12 with `iniciar` and `parar` both high at cycle 20: all outputs return to reset values at cycle 13, and the block stays in INICIAL after cycle 20.
